// File: rtl/datapath.sv
// K&S datapath: PC, IR, 4x16 register file, ALU and flags; every strobe comes from control_unit.
// No added latency: reads are combinational, state updates on the strobed clk edge.
package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP, I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNOV, I_BNZERO, I_BNNEG, I_HALT,
    I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR
  } decoded_instruction_type;
endpackage

module datapath
  import k_and_s_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    write_reg_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic [1:0]              operation,
  input  logic                    flags_reg_enable,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   data_out,
  input  logic [DATA_WIDTH-1:0]   data_in
);

  localparam int MSB = DATA_WIDTH - 1;

  typedef struct packed {
    logic zero;
    logic neg;
    logic uov;
    logic sov;
  } flags_t;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [DATA_WIDTH-1:0] regs_q [4];
  logic [DATA_WIDTH-1:0] regs_d [4];
  flags_t                flags_q, flags_d, alu_flags;
  logic [1:0]            a_sel, b_sel, dest_sel;
  logic [DATA_WIDTH-1:0] a_dat, b_dat, alu_res, wb_dat;
  logic [DATA_WIDTH:0]   sum_ext;
  logic                  unused_ir_bit;

  always_comb begin
    case (ir_q[MSB -: 8])
      8'h00:   decoded_instruction = I_NOP;
      8'h01:   decoded_instruction = I_BRANCH;
      8'h02:   decoded_instruction = I_BZERO;
      8'h03:   decoded_instruction = I_BNEG;
      8'h05:   decoded_instruction = I_BOV;
      8'h06:   decoded_instruction = I_BNOV;
      8'h0A:   decoded_instruction = I_BNZERO;
      8'h0B:   decoded_instruction = I_BNNEG;
      8'h0F:   decoded_instruction = I_HALT;
      8'h81:   decoded_instruction = I_LOAD;
      8'h82:   decoded_instruction = I_STORE;
      8'h91:   decoded_instruction = I_MOVE;
      8'hA1:   decoded_instruction = I_ADD;
      8'hA2:   decoded_instruction = I_SUB;
      8'hA3:   decoded_instruction = I_AND;
      8'hA4:   decoded_instruction = I_OR;
      default: decoded_instruction = I_NOP;
    endcase
  end

  // MOVE drives its source onto both ALU ports so OR passes it through unchanged.
  always_comb begin
    a_sel = (decoded_instruction == I_MOVE) ? ir_q[1:0] : ir_q[3:2];
    b_sel = ir_q[1:0];
    case (decoded_instruction)
      I_LOAD:  dest_sel = ir_q[6:5];
      I_MOVE:  dest_sel = ir_q[3:2];
      default: dest_sel = ir_q[5:4];
    endcase
  end

  assign a_dat  = regs_q[a_sel];
  assign b_dat  = regs_q[b_sel];
  assign wb_dat = c_sel ? alu_res : data_in;

  always_comb begin
    sum_ext   = '0;
    alu_res   = '0;
    alu_flags = '0;
    case (operation)
      2'b00: alu_res = a_dat | b_dat;
      2'b01: begin
        sum_ext       = {1'b0, a_dat} + {1'b0, b_dat};
        alu_res       = sum_ext[MSB:0];
        alu_flags.uov = sum_ext[DATA_WIDTH];
        alu_flags.sov = (a_dat[MSB] == b_dat[MSB]) && (alu_res[MSB] != a_dat[MSB]);
      end
      2'b10: begin
        // Extra top bit of the widened difference is the borrow.
        sum_ext       = {1'b0, a_dat} - {1'b0, b_dat};
        alu_res       = sum_ext[MSB:0];
        alu_flags.uov = sum_ext[DATA_WIDTH];
        alu_flags.sov = (a_dat[MSB] != b_dat[MSB]) && (alu_res[MSB] != a_dat[MSB]);
      end
      default: alu_res = a_dat & b_dat;
    endcase
    alu_flags.zero = (alu_res == '0);
    alu_flags.neg  = alu_res[MSB];
  end

  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    for (int i = 0; i < 4; i++) regs_d[i] = regs_q[i];
    if (pc_enable)        pc_d = branch ? ir_q[ADDR_WIDTH-1:0] : pc_q + ADDR_WIDTH'(1);
    if (ir_enable)        ir_d = data_in;
    if (write_reg_enable) regs_d[dest_sel] = wb_dat;
    if (flags_reg_enable) flags_d = alu_flags;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      ir_q    <= '0;
      flags_q <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
      for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign ram_addr          = addr_sel ? ir_q[ADDR_WIDTH-1:0] : pc_q;
  assign data_out          = regs_q[ir_q[6:5]];
  assign zero_op           = flags_q.zero;
  assign neg_op            = flags_q.neg;
  assign unsigned_overflow = flags_q.uov;
  assign signed_overflow   = flags_q.sov;
  assign unused_ir_bit     = ir_q[7];

endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: acts as control unit and synchronous RAM, scoreboards every cycle's outputs.
module tb_datapath;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel, flags_reg_enable;
  logic [1:0] operation;
  decoded_instruction_type decoded_instruction;
  logic zero_op, neg_op, unsigned_overflow, signed_overflow;
  logic [4:0] ram_addr;
  logic [15:0] data_out, data_in;
  logic ram_we;

  always #5 clk = ~clk;

  datapath #(.DATA_WIDTH(16), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .branch(branch), .pc_enable(pc_enable), .ir_enable(ir_enable),
    .write_reg_enable(write_reg_enable), .addr_sel(addr_sel), .c_sel(c_sel),
    .operation(operation), .flags_reg_enable(flags_reg_enable),
    .decoded_instruction(decoded_instruction), .zero_op(zero_op), .neg_op(neg_op),
    .unsigned_overflow(unsigned_overflow), .signed_overflow(signed_overflow),
    .ram_addr(ram_addr), .data_out(data_out), .data_in(data_in)
  );

  logic [15:0] mem [32];
  always @(posedge clk) begin
    data_in <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= data_out;
  end

  typedef struct packed {
    logic [3:0]  dec;
    logic        z, n, u, s;
    logic [4:0]  addr;
    logic [15:0] dout;
  } obs_t;
  typedef struct {
    obs_t  o;
    string tag;
  } exp_t;
  typedef struct packed {
    logic branch, pc_en, ir_en, wr_en, addr_sel, c_sel;
    logic [1:0] op;
    logic fl_en, we;
  } ctl_t;

  exp_t exp_q[$];
  logic chk_vld = 1'b0;
  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] m_mem [32];
  logic [15:0] m_regs [4];
  logic [15:0] m_ir, m_din;
  int m_pc;
  bit m_z, m_n, m_u, m_s;
  decoded_instruction_type op_map [int];

  function automatic decoded_instruction_type m_dec(input logic [15:0] w);
    int op;
    op = int'(w[15:8]);
    return op_map.exists(op) ? op_map[op] : I_NOP;
  endfunction

  function automatic int sval(input int u);
    return (u >= 32768) ? u - 65536 : u;
  endfunction

  task automatic m_alu(input logic [1:0] op, input int a, input int b,
                       output int r, output bit z, output bit n, output bit u, output bit s);
    int full, sf;
    u = 0;
    s = 0;
    case (op)
      2'b00: r = a | b;
      2'b11: r = a & b;
      2'b01: begin
        full = a + b;
        sf = sval(a) + sval(b);
        r = full % 65536;
        u = (full > 65535);
        s = (sf > 32767) || (sf < -32768);
      end
      default: begin
        full = a - b;
        sf = sval(a) - sval(b);
        r = (full + 65536) % 65536;
        u = (a < b);
        s = (sf > 32767) || (sf < -32768);
      end
    endcase
    z = (r == 0);
    n = (r >= 32768);
  endtask

  always @(negedge clk) begin
    if (chk_vld) begin
      obs_t act;
      exp_t e;
      act = {decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
             ram_addr, data_out};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL no_expectation: actual output present, required a queued expectation");
      end else begin
        e = exp_q.pop_front();
        if (act !== e.o) begin
          errors++;
          $display("FAIL %s: actual dec=%0d z=%0b n=%0b uov=%0b sov=%0b addr=%0d dout=%h, required dec=%0d z=%0b n=%0b uov=%0b sov=%0b addr=%0d dout=%h",
                   e.tag, act.dec, act.z, act.n, act.u, act.s, act.addr, act.dout,
                   e.o.dec, e.o.z, e.o.n, e.o.u, e.o.s, e.o.addr, e.o.dout);
        end
      end
    end
  end

  task automatic drive(input ctl_t c);
    branch = c.branch;
    pc_enable = c.pc_en;
    ir_enable = c.ir_en;
    write_reg_enable = c.wr_en;
    addr_sel = c.addr_sel;
    c_sel = c.c_sel;
    operation = c.op;
    flags_reg_enable = c.fl_en;
    ram_we = c.we;
  endtask

  task automatic push_exp(input int addr, input string tag);
    exp_t e;
    e.o.dec = m_dec(m_ir);
    e.o.z = m_z;
    e.o.n = m_n;
    e.o.u = m_u;
    e.o.s = m_s;
    e.o.addr = 5'(addr);
    e.o.dout = m_regs[m_ir[6:5]];
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // One clock of control: expectation for this cycle, then the architectural effect of the edge.
  task automatic step(input ctl_t c, input string tag);
    int addr, a_i, b_i, d_i, r;
    bit z, n, u, s;
    logic [15:0] rd, old_ir;
    decoded_instruction_type d;
    drive(c);
    addr = c.addr_sel ? int'(m_ir[4:0]) : m_pc;
    push_exp(addr, tag);
    chk_vld = 1'b1;
    rd = m_mem[addr];
    @(posedge clk);
    old_ir = m_ir;
    d = m_dec(old_ir);
    a_i = (d == I_MOVE) ? int'(old_ir[1:0]) : int'(old_ir[3:2]);
    b_i = int'(old_ir[1:0]);
    d_i = (d == I_LOAD) ? int'(old_ir[6:5]) : (d == I_MOVE) ? int'(old_ir[3:2]) : int'(old_ir[5:4]);
    m_alu(c.op, int'(m_regs[a_i]), int'(m_regs[b_i]), r, z, n, u, s);
    if (c.we) m_mem[addr] = m_regs[old_ir[6:5]];
    if (c.wr_en) m_regs[d_i] = c.c_sel ? 16'(r) : m_din;
    if (c.fl_en) begin
      m_z = z; m_n = n; m_u = u; m_s = s;
    end
    if (c.pc_en) m_pc = c.branch ? int'(old_ir[4:0]) : (m_pc + 1) % 32;
    if (c.ir_en) m_ir = m_din;
    m_din = rd;
    #1;
    chk_vld = 1'b0;
    drive('0);
  endtask

  task automatic fetch(input logic [15:0] w);
    ctl_t c;
    m_mem[m_pc] = w;
    mem[m_pc] = w;
    step('0, "fetch_addr");
    c = '0; c.ir_en = 1'b1; c.pc_en = 1'b1;
    step(c, "fetch_ir");
  endtask

  task automatic execute();
    ctl_t c;
    bit take;
    decoded_instruction_type d;
    d = m_dec(m_ir);
    c = '0;
    case (d)
      I_ADD, I_SUB, I_AND, I_OR, I_MOVE: begin
        c.wr_en = 1'b1; c.c_sel = 1'b1; c.fl_en = 1'b1;
        c.op = (d == I_ADD) ? 2'b01 : (d == I_SUB) ? 2'b10 : (d == I_AND) ? 2'b11 : 2'b00;
        step(c, "alu");
      end
      I_LOAD: begin
        c.addr_sel = 1'b1;
        step(c, "load_addr");
        c = '0; c.wr_en = 1'b1;
        step(c, "load_wb");
      end
      I_STORE: begin
        c.addr_sel = 1'b1; c.we = 1'b1;
        step(c, "store");
      end
      I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNOV, I_BNZERO, I_BNNEG: begin
        case (d)
          I_BRANCH: take = 1'b1;
          I_BZERO:  take = m_z;
          I_BNEG:   take = m_n;
          I_BOV:    take = m_u | m_s;
          I_BNOV:   take = !(m_u | m_s);
          I_BNZERO: take = !m_z;
          default:  take = !m_n;
        endcase
        c.branch = take; c.pc_en = take;
        step(c, "branch");
      end
      default: step(c, "idle");
    endcase
  endtask

  task automatic run(input logic [15:0] w);
    fetch(w);
    execute();
  endtask

  task automatic load_reg(input logic [1:0] r, input logic [4:0] a, input logic [15:0] v);
    fetch({8'h81, 1'b0, r, a});
    m_mem[a] = v;
    mem[a] = v;
    execute();
  endtask

  task automatic reset_mid();
    ctl_t c;
    c = '0; c.wr_en = 1'b1; c.c_sel = 1'b1; c.fl_en = 1'b1; c.op = 2'b01;
    drive(c);
    #2;
    rst_n = 1'b0;
    m_pc = 0; m_ir = '0;
    m_z = 0; m_n = 0; m_u = 0; m_s = 0;
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    push_exp(0, "reset_mid");
    chk_vld = 1'b1;
    @(posedge clk);
    #1;
    chk_vld = 1'b0;
    drive('0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_din = m_mem[0];
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] alu_ops [4];
    logic [7:0] br_ops [7];
    logic [15:0] v;
    ctl_t c;
    int k;
    alu_ops = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    br_ops = '{8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h0A, 8'h0B};
    op_map[8'h00] = I_NOP;    op_map[8'h01] = I_BRANCH; op_map[8'h02] = I_BZERO;
    op_map[8'h03] = I_BNEG;   op_map[8'h05] = I_BOV;    op_map[8'h06] = I_BNOV;
    op_map[8'h0A] = I_BNZERO; op_map[8'h0B] = I_BNNEG;  op_map[8'h0F] = I_HALT;
    op_map[8'h81] = I_LOAD;   op_map[8'h82] = I_STORE;  op_map[8'h91] = I_MOVE;
    op_map[8'hA1] = I_ADD;    op_map[8'hA2] = I_SUB;    op_map[8'hA3] = I_AND;
    op_map[8'hA4] = I_OR;
    for (int i = 0; i < 32; i++) begin
      mem[i] = '0;
      m_mem[i] = '0;
    end
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_ir = '0; m_din = '0; m_pc = 0;
    m_z = 0; m_n = 0; m_u = 0; m_s = 0;
    drive('0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    step('0, "reset_state");
    fetch(16'hA110);
    step('0, "fetch_decode");
    execute();

    load_reg(2'd1, 5'h1C, 16'h7FFF);
    load_reg(2'd2, 5'h1D, 16'h0001);
    run(16'hA106);
    run({8'h82, 1'b0, 2'd0, 5'h1A});

    load_reg(2'd1, 5'h1C, 16'h0003);
    load_reg(2'd2, 5'h1D, 16'h0005);
    run(16'hA236);
    run({8'h82, 1'b0, 2'd3, 5'h1A});
    run(16'hA205);

    load_reg(2'd2, 5'h1E, 16'h1234);
    run(16'h825F);
    run(16'h817F);
    run(16'h827B);

    run(16'h0107);
    c = '0; c.branch = 1'b1;
    step(c, "branch_no_enable");
    run(16'h011F);
    run(16'h0000);
    step('0, "pc_wrapped");

    load_reg(2'd1, 5'h1C, 16'h00FF);
    run(16'h910D);
    run({8'h82, 1'b0, 2'd3, 5'h1B});
    run(16'h04FF);
    run(16'hFF00);

    fetch(16'hA115);
    reset_mid();
    for (int r = 0; r < 4; r++) run({8'h82, 1'b0, 2'(r), 5'h10});

    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 9);
      case ($urandom_range(0, 4))
        0: v = 16'h7FFF;
        1: v = 16'h8000;
        2: v = 16'hFFFF;
        3: v = 16'h0000;
        default: v = 16'($urandom);
      endcase
      case (k)
        0, 1: load_reg(2'($urandom), 5'($urandom), v);
        2: run({8'h82, 8'($urandom)});
        3, 4, 5, 6: run({alu_ops[$urandom_range(0, 3)], 8'($urandom)});
        7: run({8'h91, 8'($urandom)});
        8: run({br_ops[$urandom_range(0, 6)], 8'($urandom)});
        default: run(16'($urandom));
      endcase
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: actual %0d pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
